// File: rtl/fp_conv_pkg.sv
// Shared widths, typedefs and state encoding for the
// linear-to-float converter front end and rounding stage.
package fp_conv_pkg;

  localparam int IN_W    = 12;
  localparam int EXP_W   = 3;
  localparam int SIG_W   = 4;
  localparam int MAX_EXP = 2**EXP_W - 1;
  localparam int MAG_W   = IN_W - 1;

  typedef logic [EXP_W-1:0] exp_t;
  typedef logic [SIG_W-1:0] sig_t;
  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/twos_to_mag.sv
// Two's-complement to sign-magnitude, saturating the
// most negative code to the largest magnitude.
module twos_to_mag
  import fp_conv_pkg::*;
(
  input  logic [IN_W-1:0] data,
  output logic [IN_W-1:0] sm
);

  logic [IN_W-1:0] neg;
  logic            sign;
  mag_t            mag;

  always_comb begin
    sign = data[IN_W-1];
    neg  = (~data) + 1'b1;
    mag  = data[MAG_W-1:0];
    if (sign) begin
      // -2**(IN_W-1) negates to itself; clamp it
      if (neg[IN_W-1]) mag = '1;
      else             mag = neg[MAG_W-1:0];
    end
    sm = {sign, mag};
  end

endmodule

// File: rtl/fp_normalizer_seq.sv
// Sequential normaliser: accepts a sample, shifts one bit
// per clock and registers sign/exponent/significand/round bit.
module fp_normalizer_seq
  import fp_conv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            sign_out,
  output exp_t            exp_out,
  output sig_t            sig_out,
  output logic            fifth_out,
  output logic            out_valid,
  input  logic            out_ready
);

  state_t          state;
  state_t          state_nx;
  logic [IN_W-1:0] sm;
  mag_t            mag;
  exp_t            e;
  logic            sign;
  logic            load;
  logic            shift;
  logic            latch;

  twos_to_mag u_abs (
    .data (in_data),
    .sm   (sm)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    latch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (mag[MAG_W-1] || e == '0) begin
          latch    = 1'b1;
          state_nx = DONE;
        end else begin
          shift = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
      mag  <= '0;
      e    <= '0;
    end else if (load) begin
      sign <= sm[IN_W-1];
      mag  <= sm[MAG_W-1:0];
      e    <= exp_t'(MAX_EXP);
    end else if (shift) begin
      mag <= {mag[MAG_W-2:0], 1'b0};
      e   <= e - 1'b1;
    end
  end

  // Result registers only move on SHIFT->DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_out  <= 1'b0;
      exp_out   <= '0;
      sig_out   <= '0;
      fifth_out <= 1'b0;
    end else if (latch) begin
      sign_out  <= sign;
      exp_out   <= e;
      sig_out   <= mag[MAG_W-1 -: SIG_W];
      fifth_out <= mag[MAG_W-1-SIG_W];
    end
  end

endmodule

// File: tb/tb_fp_normalizer_seq.sv
// Directed bench for fp_normalizer_seq with hand-computed
// expected results and latency checks.
module tb_fp_normalizer_seq;

  logic        clk;
  logic        rst_n;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        sign_out;
  logic [2:0]  exp_out;
  logic [3:0]  sig_out;
  logic        fifth_out;
  logic        out_valid;
  logic        out_ready;

  int total;
  int passed;

  fp_normalizer_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .sig_out   (sig_out),
    .fifth_out (fifth_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && in_ready) begin
      total++;
      $error("FAIL overlap observed=1 expected=0");
    end
  end

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic check_res(input string tag, input logic s,
                           input logic [2:0] ex, input logic [3:0] sg,
                           input logic f);
    chk({tag, "_valid"}, 12'(out_valid), 12'd1);
    chk({tag, "_sign"},  12'(sign_out), 12'(s));
    chk({tag, "_exp"},   12'(exp_out), 12'(ex));
    chk({tag, "_sig"},   12'(sig_out), 12'(sg));
    chk({tag, "_fifth"}, 12'(fifth_out), 12'(f));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, 12'(out_valid), 12'd0);
    chk({tag, "_done_ready"}, 12'(in_ready), 12'd1);
  endtask

  task automatic run(input string tag, input logic [11:0] d,
                     input int lat, input logic s, input logic [2:0] ex,
                     input logic [3:0] sg, input logic f);
    int cnt;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, 12'(in_ready), 12'd0);
    wait_out(cnt);
    chk({tag, "_lat"}, 12'(cnt), 12'(lat));
    check_res(tag, s, ex, sg, f);
    consume(tag);
  endtask

  initial begin
    int cnt;
    logic seen;
    total     = 0;
    passed    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_ready", 12'(in_ready), 12'd1);
    chk("rst_valid", 12'(out_valid), 12'd0);
    chk("rst_exp",   12'(exp_out), 12'd0);
    chk("rst_sig",   12'(sig_out), 12'd0);
    chk("rst_fifth", 12'(fifth_out), 12'd0);
    chk("rst_sign",  12'(sign_out), 12'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("t46", 12'd46, 6, 1'b0, 3'd2, 4'b1011, 1'b1);
    run("tmax", 12'h7FF, 1, 1'b0, 3'd7, 4'b1111, 1'b1);
    run("tmin", 12'h800, 1, 1'b1, 3'd7, 4'b1111, 1'b1);

    // back-to-back with in_valid held high
    in_data  = 12'd422;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 12'hE5A;
    wait_out(cnt);
    chk("b2b_lat1", 12'(cnt), 12'd3);
    chk("b2b_busy1", 12'(in_ready), 12'd0);
    check_res("b2b1", 1'b0, 3'd5, 4'b1101, 1'b0);
    consume("b2b1");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_acc2", 12'(in_ready), 12'd0);
    wait_out(cnt);
    chk("b2b_lat2", 12'(cnt), 12'd3);
    check_res("b2b2", 1'b1, 3'd5, 4'b1101, 1'b0);
    consume("b2b2");

    run("tzero", 12'd0, 8, 1'b0, 3'd0, 4'b0000, 1'b0);

    // backpressure
    in_data  = 12'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(cnt);
    chk("bp_lat", 12'(cnt), 12'd8);
    for (int i = 0; i < 10; i++) begin
      check_res("bp", 1'b0, 3'd0, 4'b0101, 1'b0);
      chk("bp_ready", 12'(in_ready), 12'd0);
      @(posedge clk); #1;
    end
    consume("bp");

    // reset in the middle of SHIFT
    in_data  = 12'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("mrst_ready", 12'(in_ready), 12'd1);
    chk("mrst_valid", 12'(out_valid), 12'd0);
    chk("mrst_sig",   12'(sig_out), 12'd0);
    chk("mrst_exp",   12'(exp_out), 12'd0);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mrst_nopulse", 12'(seen), 12'd0);
    run("t46b", 12'd46, 6, 1'b0, 3'd2, 4'b1011, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
